// File: rtl/instr_encoder.sv
// instr_encoder: encodes LW/SW/R-type requests into 32-bit words and streams them into instruction memory.
// Optional build macro INSTR_ENCODER_CHECKSUM_EN adds a running XOR checksum of the written words.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_kind,
    output logic              err_full,
    output logic [31:0]       checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_t state, state_nx;
    logic   full_q, accept, wr_done, at_end, kind_bad, do_write, do_drop, session_start;
    function automatic logic [31:0] encode(input logic [2:0] kind, input logic [4:0] rs, rt, rd,
                                           input logic [15:0] imm);
        logic [5:0] funct;
        funct = (kind == 3'd2) ? 6'd32 : (kind == 3'd3) ? 6'd34 : (kind == 3'd4) ? 6'd50 :
                (kind == 3'd5) ? 6'd36 : 6'd37;
        return (kind == 3'd0) ? {6'd5, rs, rt, imm} :
               (kind == 3'd1) ? {6'd6, rs, rt, imm} : {6'd4, rs, rt, rd, 5'd0, funct};
    endfunction
    assign req_ready     = (state == LOAD) && (!imem_we || imem_ready);
    assign accept        = req_valid && req_ready;
    assign wr_done       = imem_we && imem_ready;
    // Memory is exhausted once the top address has been written, including in the completing cycle.
    assign at_end        = full_q || (wr_done && imem_addr == LAST);
    assign kind_bad      = req_kind == 3'd7;
    assign do_write      = accept && !kind_bad && !at_end;
    assign do_drop       = accept && !kind_bad && at_end;
    assign session_start = (state == IDLE) && start;
    assign busy          = (state == LOAD) || (state == DRAIN);
    assign done          = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = ((accept && req_last) || do_drop) ? DRAIN : LOAD;
            DRAIN:   state_nx = (!imem_we || imem_ready) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_wdata <= '0;
        end else if (do_write) begin
            imem_we    <= 1'b1;
            imem_wdata <= encode(req_kind, req_rs, req_rt, req_rd, req_imm);
        end else if (imem_ready) begin
            imem_we    <= 1'b0;
        end
    end
    // The address saturates at the top; full_q records that the last slot is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= BASE;
            full_q    <= 1'b0;
        end else if (session_start) begin
            imem_addr <= BASE;
            full_q    <= 1'b0;
        end else if (wr_done) begin
            if (imem_addr == LAST) full_q    <= 1'b1;
            else                   imem_addr <= imem_addr + ADDR_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_kind <= 1'b0;
            err_full <= 1'b0;
        end else if (session_start) begin
            err_kind <= 1'b0;
            err_full <= 1'b0;
        end else begin
            if (accept && kind_bad) err_kind <= 1'b1;
            if (do_drop)            err_full <= 1'b1;
        end
    end
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] cs_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cs_q <= '0;
        else if (session_start) cs_q <= '0;
        else if (wr_done)       cs_q <= cs_q ^ imem_wdata;
    end
    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed requests; expected writes go to a queue checked by an independent write monitor.
module tb_instr_encoder;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, req_valid = 1'b0, req_last = 1'b0;
    logic        imem_ready = 1'b1;
    logic [2:0]  req_kind = '0;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
    logic [15:0] req_imm = '0;
    logic        req_ready, imem_we, busy, done, err_kind, err_full;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata, checksum;
    logic [63:0] sb_q[$];
    logic [63:0] sb_e;
    int          n_cmp = 0, n_bad = 0;
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .req_last(req_last), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_kind(err_kind), .err_full(err_full),
        .checksum(checksum)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                sb_e = sb_q.pop_front();
                chk("write_addr", {30'd0, imem_addr}, sb_e[63:32]);
                chk("write_data", imem_wdata, sb_e[31:0]);
            end
        end
    end
    task automatic sync();
        @(posedge clk);
        #1;
    endtask
    task automatic start_pulse();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask
    task automatic send(input logic [2:0] k, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                        input logic last, input logic push, input logic [31:0] ea, input logic [31:0] ed);
        int t;
        req_valid = 1'b1; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_last = last;
        if (push) sb_q.push_back({ea, ed});
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 100);
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        sync();
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask
    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 50);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, imem_we}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_addr", {30'd0, imem_addr}, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_errs", {30'd0, err_kind, err_full}, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_ready", {31'd0, req_ready}, 0);
        rst_n = 1'b1;
        sync();
        // single LW with last: write next cycle, done the cycle after
        start_pulse();
        send(3'd0, 5'd1, 5'd2, 5'd0, 16'h0010, 1'b1, 1'b1, 32'd0, 32'h14220010);
        chk("lw_we", {31'd0, imem_we}, 1);
        chk("lw_wdata", imem_wdata, 32'h14220010);
        @(negedge clk);
        chk("lw_done_early", {31'd0, done}, 0);
        @(negedge clk);
        chk("lw_done", {31'd0, done}, 1);
        @(negedge clk);
        chk("lw_done_once", {31'd0, done}, 0);
        chk("lw_idle_busy", {31'd0, busy}, 0);
        sync();
        // ADD then MUL back to back, checksum of both words
        start_pulse();
        chk("busy_load", {31'd0, busy}, 1);
        send(3'd2, 5'd3, 5'd4, 5'd5, 16'hFFFF, 1'b0, 1'b1, 32'd0, 32'h10642820);
        send(3'd4, 5'd1, 5'd1, 5'd1, 16'h1234, 1'b1, 1'b1, 32'd1, 32'h10210832);
        wait_done();
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("checksum", checksum, 32'h00452012);
`else
        chk("checksum", checksum, 32'h0);
`endif
        sync();
        // SW stalled for 3 cycles, then a follow-on ADD at the next address
        start_pulse();
        imem_ready = 1'b0;
        send(3'd1, 5'd0, 5'd7, 5'd9, 16'hFFFC, 1'b0, 1'b1, 32'd0, 32'h1807FFFC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", {31'd0, imem_we}, 1);
            chk("stall_wdata", imem_wdata, 32'h1807FFFC);
            chk("stall_addr", {30'd0, imem_addr}, 0);
            chk("stall_ready", {31'd0, req_ready}, 0);
        end
        sync();
        imem_ready = 1'b1;
        chk("stall_wdata4", imem_wdata, 32'h1807FFFC);
        send(3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b1, 32'd1, 32'h10221820);
        wait_done();
        sync();
        // five ADDs into a 4-entry memory: fifth dropped, no wrap
        start_pulse();
        for (int k = 1; k <= 5; k++)
            send(3'd2, 5'(k), 5'd0, 5'd0, 16'h0, 1'b0, k < 5, 32'(k - 1), 32'h10000020 | (32'(k) << 21));
        wait_done();
        chk("full_err_full", {31'd0, err_full}, 1);
        chk("full_err_kind", {31'd0, err_kind}, 0);
        chk("full_addr", {30'd0, imem_addr}, 3);
        sync();
        // kind 7 between two ORs
        start_pulse();
        chk("start_clears_full", {31'd0, err_full}, 0);
        send(3'd6, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'd0, 32'h10221825);
        send(3'd7, 5'd9, 5'd9, 5'd9, 16'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        send(3'd6, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1, 1'b1, 32'd1, 32'h10853025);
        wait_done();
        chk("kind_err", {31'd0, err_kind}, 1);
        sync();
        start_pulse();
        chk("start_clears_kind", {31'd0, err_kind}, 0);
        send(3'd7, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done();
        chk("kind_last_err", {31'd0, err_kind}, 1);
        sync();
        // stalled second write: start ignored, then reset mid-stall
        start_pulse();
        send(3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'd0, 32'h10221820);
        send(3'd0, 5'd1, 5'd2, 5'd0, 16'h0010, 1'b0, 1'b0, 32'd0, 32'd0);
        imem_ready = 1'b0;
        start_pulse();
        chk("ign_start_we", {31'd0, imem_we}, 1);
        chk("ign_start_addr", {30'd0, imem_addr}, 1);
        chk("ign_start_wdata", imem_wdata, 32'h14220010);
        chk("ign_start_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, imem_we}, 0);
        chk("async_rst_busy", {31'd0, busy}, 0);
        chk("async_rst_addr", {30'd0, imem_addr}, 0);
        chk("async_rst_wdata", imem_wdata, 0);
        sync();
        sync();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_we", {31'd0, imem_we}, 0);
            chk("post_rst_ready", {31'd0, req_ready}, 0);
        end
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter BASE_ADDR, default 0, first address written after each start.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse that begins a program-load session.
REQ-006 req_valid  in  1  source is offering an encode request.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_kind  in  3  request kind: 0 LW, 1 SW, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 invalid.
REQ-009 req_rs, req_rt, req_rd  in  5 each  register fields.
REQ-010 req_imm  in  16  immediate field, LW/SW only.
REQ-011 req_last  in  1  marks the final request of the session.
REQ-012 imem_we  out  1  write strobe, doubles as write-valid.
REQ-013 imem_ready  in  1  memory accepts the write this cycle.
REQ-014 imem_addr  out  ADDR_W  write address.
REQ-015 imem_wdata  out  32  encoded instruction word.
REQ-016 busy  out  1  high in LOAD and DRAIN states.
REQ-017 done  out  1  one-cycle pulse at session end.
REQ-018 err_kind, err_full  out  1 each  sticky error flags, cleared by start.
REQ-019 checksum  out  32  XOR of all words written in the session.

Function
REQ-020 FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE to LOAD on start.
- LOAD to DRAIN on acceptance of req_last, or on err_full.
- DRAIN to DONE once no write is pending.
- DONE to IDLE unconditionally after one cycle.
REQ-021 start outside IDLE is ignored; all state, flags and address are unaffected.
REQ-022 A request is accepted when req_valid && req_ready; req_ready = (state==LOAD) && (!imem_we || imem_ready).
REQ-023 LW encoding: [31:26]=5, [25:21]=rs, [20:16]=rt, [15:0]=imm.
REQ-024 SW encoding: identical to LW except [31:26]=6.
REQ-025 R-type encoding: [31:26]=4, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=0, [5:0]=funct.
- funct values: ADD 32, SUB 34, MUL 50, AND 36, OR 37.
- req_imm is ignored for R-type; req_rd is ignored for LW/SW.
REQ-026 Latency: an accepted request appears on imem_we/imem_addr/imem_wdata in the next cycle (registered output).
REQ-027 imem_we, imem_addr and imem_wdata are held stable while imem_we && !imem_ready.
REQ-028 The address counter loads BASE_ADDR on start and increments by 1 per completed write (imem_we && imem_ready).
REQ-029 Kind 7: the request is consumed but not written; err_kind is set; the session continues.
REQ-030 Memory full: a request accepted after the write at address 2^ADDR_W-1 completes is dropped; err_full is set; the FSM moves to DRAIN; the address never wraps.
REQ-031 done pulses in the DONE state; busy is low in IDLE and DONE.
REQ-032 req_last on a kind-7 request still ends the session.

Reset
REQ-033 Asynchronous on rst_n low, effective immediately, including mid-session and mid-stall.
REQ-034 Reset values:
- state = IDLE.
- imem_we, done, busy, err_kind, err_full = 0.
- imem_addr = BASE_ADDR.
- imem_wdata = 0, checksum = 0.
REQ-035 Any pending write is discarded at reset; no write strobe is issued on reset release.

Configuration
REQ-036 Macro INSTR_ENCODER_CHECKSUM_EN.
- Defined: checksum is cleared on start and XORed with imem_wdata on each completed write.
- Undefined: checksum is tied to 0 and no checksum logic is present.

Verification
REQ-037 start; LW rs=1 rt=2 imm=0x0010 with req_last -> next cycle imem_we=1, addr 0, wdata 0x14220010; one cycle later done pulse.
REQ-038 ADD rs=3 rt=4 rd=5, then MUL rs=1 rt=1 rd=1 (last), imem_ready=1 -> wdata 0x10642820 at addr 0 then 0x10210832 at addr 1; with CHECKSUM_EN, checksum=0x00452012.
REQ-039 SW rs=0 rt=7 imm=0xFFFC with imem_ready=0 for 3 cycles -> wdata 0x1807FFFC held 4 cycles, req_ready=0 during the stall, address increments only after the accepted write.
REQ-040 ADDR_W=2, five ADD requests -> writes at addr 0..3, fifth dropped, err_full=1, done pulse, no write to addr 0 again.
REQ-041 Kind 7 between two OR requests -> two writes at consecutive addresses, err_kind=1; next start clears err_kind.
REQ-042 rst_n low while imem_we=1 and stalled -> imem_we=0 immediately, state IDLE; after release, no write until a new start.
